cass_player: RTL and testbench

- Tape-image playback engine for the TRS-80 cassette input path, sitting directly upstream of the CPU's port-FF read logic.
- Reads a cassette image byte-by-byte from a synchronous ROM/RAM (1-cycle read latency, same as the game ROM).
- Emits the Level II 500-baud pulse stream, and keeps the port-FF bit-7 pulse latch that the CPU polls and clears.
- Motor control comes from the cassette-out register (tape_bits[2]).

---
 rtl/cass_player.sv | 197 +++++++++++++++++++
 tb/tb_cass_player.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cass_player.sv
// TRS-80 cassette playback engine: streams a tape image from synchronous memory
// as the Level II 500-baud pulse train and keeps the port-FF bit-7 pulse latch.
module cass_player #(
  parameter int ADDR_BITS    = 14,
  parameter int BIT_CYCLES   = 56000,
  parameter int PULSE_CYCLES = 4200,
  parameter int HALF_CYCLES  = 28000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 motor,
  input  logic [ADDR_BITS-1:0] len,
  output logic                 rd,
  output logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           data,
  output logic                 cass_pulse,
  input  logic                 clr_latch,
  output logic                 cass_latch,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PULSE = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF_CYCLES);
  localparam logic [CW-1:0] CNT_DEND  = CW'(HALF_CYCLES + PULSE_CYCLES);
  localparam logic [ADDR_BITS-1:0] ADDR_ZERO = ADDR_BITS'(0);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, PLAY = 2'd2, DONE = 2'd3} state_t;

  state_t               state_r, state_s;
  logic [ADDR_BITS-1:0] addr_r, addr_s, addr_inc_s;
  logic                 rd_r, rd_s, rd_d_r;
  logic                 load_r, load_s;
  logic [7:0]           shift_r, shift_s, next_byte_r;
  logic [2:0]           bit_r, bit_s, bit_dec_s;
  logic [CW-1:0]        cnt_r, cnt_s, cnt_inc_s;
  logic                 has_next_r, has_next_s;
  logic                 pulse_r, pulse_s, pulse_prev_r;
  logic                 latch_r, busy_r, done_r;

  // Clock pulse at every cell start; data pulse mid-cell only for a 1 bit.
  function automatic logic pulse_at(input logic [CW-1:0] c, input logic b);
    pulse_at = (c < CNT_PULSE) | (b & (c >= CNT_HALF) & (c < CNT_DEND));
  endfunction

  assign addr_inc_s = addr_r + ADDR_ONE;
  assign bit_dec_s  = bit_r - 3'd1;
  assign cnt_inc_s  = cnt_r + CNT_ONE;

  // Next-state and datapath decisions; outputs are registered from these values.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    rd_s       = 1'b0;
    load_s     = 1'b0;
    shift_s    = shift_r;
    bit_s      = bit_r;
    cnt_s      = cnt_r;
    has_next_s = has_next_r;
    pulse_s    = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s      = CNT_ZERO;
        bit_s      = 3'd0;
        has_next_s = 1'b0;
        if (motor) begin
          if (len != ADDR_ZERO) begin
            state_s = FETCH;
            addr_s  = ADDR_ZERO;
            rd_s    = 1'b1;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (!motor) begin
          state_s = IDLE;
        end else begin
          state_s = PLAY;
          load_s  = 1'b1;
        end
      end
      PLAY: begin
        if (!motor) begin
          state_s    = IDLE;
          cnt_s      = CNT_ZERO;
          bit_s      = 3'd0;
          has_next_s = 1'b0;
        end else if (load_r) begin
          shift_s    = data;
          bit_s      = 3'd7;
          cnt_s      = CNT_ZERO;
          has_next_s = 1'b0;
          pulse_s    = pulse_at(CNT_ZERO, data[7]);
        end else if (cnt_r == CNT_LAST) begin
          cnt_s = CNT_ZERO;
          if (bit_r == 3'd0) begin
            if (has_next_r) begin
              shift_s    = next_byte_r;
              bit_s      = 3'd7;
              has_next_s = 1'b0;
              pulse_s    = pulse_at(CNT_ZERO, next_byte_r[7]);
            end else begin
              state_s = DONE;
            end
          end else begin
            bit_s   = bit_dec_s;
            pulse_s = pulse_at(CNT_ZERO, shift_r[bit_dec_s]);
            // Entering the last bit cell: prefetch so the next byte is ready at cell end.
            if ((bit_dec_s == 3'd0) && (addr_inc_s < len)) begin
              addr_s     = addr_inc_s;
              rd_s       = 1'b1;
              has_next_s = 1'b1;
            end else begin
              has_next_s = has_next_r;
            end
          end
        end else begin
          cnt_s   = cnt_inc_s;
          pulse_s = pulse_at(cnt_inc_s, shift_r[bit_r]);
        end
      end
      DONE: begin
        if (!motor) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      addr_r       <= ADDR_ZERO;
      rd_r         <= 1'b0;
      rd_d_r       <= 1'b0;
      load_r       <= 1'b0;
      shift_r      <= 8'h00;
      next_byte_r  <= 8'h00;
      bit_r        <= 3'd0;
      cnt_r        <= CNT_ZERO;
      has_next_r   <= 1'b0;
      pulse_r      <= 1'b0;
      pulse_prev_r <= 1'b0;
      latch_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      rd_r         <= rd_s;
      rd_d_r       <= rd_r;
      load_r       <= load_s;
      shift_r      <= shift_s;
      bit_r        <= bit_s;
      cnt_r        <= cnt_s;
      has_next_r   <= has_next_s;
      pulse_r      <= pulse_s;
      pulse_prev_r <= pulse_r;
      busy_r       <= (state_s == FETCH) || (state_s == PLAY);
      done_r       <= (state_s == DONE);
      if (rd_d_r) begin
        next_byte_r <= data;
      end else begin
        next_byte_r <= next_byte_r;
      end
      // A pulse rising edge beats a simultaneous CPU clear.
      if (pulse_r && !pulse_prev_r) begin
        latch_r <= 1'b1;
      end else if (clr_latch) begin
        latch_r <= 1'b0;
      end else begin
        latch_r <= latch_r;
      end
    end
  end

  assign rd         = rd_r;
  assign addr       = addr_r;
  assign cass_pulse = pulse_r;
  assign cass_latch = latch_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_cass_player.sv
// Scoreboard bench for cass_player: expected per-cycle outputs are queued when
// the motor is raised and compared cycle by cycle against the DUT.
module tb_cass_player;
  localparam int AB = 14;
  localparam int BC = 20;
  localparam int PC = 3;
  localparam int HC = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          motor = 1'b0;
  logic [AB-1:0] len = '0;
  logic          rd;
  logic [AB-1:0] addr;
  logic [7:0]    data = 8'h00;
  logic          cass_pulse;
  logic          clr_latch = 1'b0;
  logic          cass_latch;
  logic          busy;
  logic          done;

  logic [7:0] mem [0:15];

  typedef struct {
    logic          rd;
    logic [AB-1:0] addr;
    logic          pulse;
    logic          busy;
    logic          done;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;

  cass_player #(.ADDR_BITS(AB), .BIT_CYCLES(BC), .PULSE_CYCLES(PC), .HALF_CYCLES(HC)) dut (
    .clk(clk), .reset(reset), .motor(motor), .len(len), .rd(rd), .addr(addr),
    .data(data), .cass_pulse(cass_pulse), .clr_latch(clr_latch),
    .cass_latch(cass_latch), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Image memory with one-cycle read latency.
  always @(posedge clk) begin
    if (rd) data <= mem[addr[3:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask

  // Queue the expected trace from the first cycle after motor is sampled high.
  task automatic push_image(input int n);
    exp_t e;
    e = '{rd: 1'b1, addr: '0, pulse: 1'b0, busy: 1'b1, done: 1'b0};
    q.push_back(e);
    e = '{rd: 1'b0, addr: '0, pulse: 1'b0, busy: 1'b1, done: 1'b0};
    q.push_back(e);
    for (int p = 0; p < n * 8 * BC; p++) begin
      int j, c;
      logic [7:0] b;
      logic bv;
      j  = p / BC;
      c  = p % BC;
      b  = mem[j / 8];
      bv = b[7 - (j % 8)];
      e.pulse = (c < PC) || (bv && (c >= HC) && (c < HC + PC));
      e.rd    = (c == 0) && (j % 8 == 7) && (j / 8 + 1 < n);
      e.addr  = AB'(j / 8 + 1);
      e.busy  = 1'b1;
      e.done  = 1'b0;
      q.push_back(e);
    end
    e = '{rd: 1'b0, addr: '0, pulse: 1'b0, busy: 1'b0, done: 1'b1};
    q.push_back(e);
  endtask

  task automatic drain(input int count);
    exp_t e;
    for (int k = 0; k < count; k++) begin
      @(negedge clk);
      e = q.pop_front();
      check_eq("rd", rd, e.rd);
      if (e.rd) check_eq("addr", addr, e.addr);
      check_eq("pulse", cass_pulse, e.pulse);
      check_eq("busy", busy, e.busy);
      check_eq("done", done, e.done);
    end
  endtask

  task automatic play(input int n);
    len = AB'(n);
    @(negedge clk);
    motor = 1'b1;
    push_image(n);
    drain(q.size());
    motor = 1'b0;
    @(negedge clk);
    check_eq("idle_done", done, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_pulse", cass_pulse, 1'b0);
    check_eq("rst_rd", rd, 1'b0);
    check_eq("rst_addr", addr, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_latch", cass_latch, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0xA5.
    mem[0] = 8'hA5;
    play(1);

    // Three bytes, contiguous playback with two prefetches.
    mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'h80;
    play(3);

    // Motor abort at play cycle 50 then full replay from addr 0.
    mem[0] = 8'hA5;
    len = AB'(1);
    @(negedge clk);
    motor = 1'b1;
    push_image(1);
    drain(3 + 50);
    motor = 1'b0;
    q.delete();
    @(negedge clk);
    check_eq("abort_pulse", cass_pulse, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    play(1);

    // Empty image.
    len = '0;
    @(negedge clk);
    motor = 1'b1;
    @(negedge clk);
    check_eq("empty_done", done, 1'b1);
    check_eq("empty_rd", rd, 1'b0);
    check_eq("empty_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("empty_pulse", cass_pulse, 1'b0);
    check_eq("empty_rd2", rd, 1'b0);
    motor = 1'b0;
    repeat (2) @(negedge clk);

    // Latch: clear before play, set-wins, clear alone, set again on next pulse.
    clr_latch = 1'b1;
    @(negedge clk);
    clr_latch = 1'b0;
    check_eq("latch_clr0", cass_latch, 1'b0);
    mem[0] = 8'h00;
    len = AB'(1);
    motor = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("latch_rise_pulse", cass_pulse, 1'b1);
    clr_latch = 1'b1;
    @(negedge clk);
    clr_latch = 1'b0;
    check_eq("latch_set_wins", cass_latch, 1'b1);
    repeat (2) @(negedge clk);
    clr_latch = 1'b1;
    @(negedge clk);
    clr_latch = 1'b0;
    check_eq("latch_cleared", cass_latch, 1'b0);
    repeat (16) @(negedge clk);
    check_eq("latch_pre_pulse", cass_latch, 1'b0);
    check_eq("latch_pulse2", cass_pulse, 1'b1);
    @(negedge clk);
    check_eq("latch_set_again", cass_latch, 1'b1);
    motor = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-play.
    mem[0] = 8'hA5;
    len = AB'(1);
    @(negedge clk);
    motor = 1'b1;
    push_image(1);
    drain(3 + 30);
    q.delete();
    #2 reset = 1'b1;
    #1;
    check_eq("arst_pulse", cass_pulse, 1'b0);
    check_eq("arst_rd", rd, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_done", done, 1'b0);
    check_eq("arst_latch", cass_latch, 1'b0);
    check_eq("arst_addr", addr, '0);
    motor = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
